trace_arbiter: RTL and testbench

TRACE_ARBITER -- requirements
Module: trace_arbiter

---
 rtl/trace_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 35 +++
 rtl/trace_arbiter.sv | 126 ++++++++++++
 tb/tb_trace_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared definitions for the trace arbiter: FSM encoding and the helpers that
// derive record field widths from the block parameters.
package trace_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    // Bounded loop keeps this usable for constant elaboration as well as synthesis.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int id_width(input int num_src);
        return (clog2(num_src) < 1) ? 1 : clog2(num_src);
    endfunction

    function automatic int ts_width(input int width, input int evt_width, input int num_src);
        return width - evt_width - id_width(num_src);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first eligible requester at or after ptr, wrapping
// around; masked requesters are skipped for this cycle.
module rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ-1:0]   mask,
    input  logic [IDX_WIDTH-1:0] ptr,
    output logic                 grant_valid,
    output logic [IDX_WIDTH-1:0] grant_idx
);

    logic [NUM_REQ-1:0] eligible;

    assign eligible = req & ~mask;

    always_comb begin : search
        int idx;
        // NOTE: every combinational output gets a default before any branch, so
        // no path leaves it unassigned and no latch is inferred.
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!grant_valid && eligible[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_WIDTH'(idx);
            end
        end
    end

endmodule

// File: rtl/trace_arbiter.sv
// Merges per-source trace events into timestamped records for a single FIFO,
// one record per cycle when sustained, with round-robin fairness.
module trace_arbiter
    import trace_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int EVT_WIDTH = 16,
    parameter int WIDTH     = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         enable,
    input  logic [NUM_SRC-1:0]           src_req,
    input  logic [NUM_SRC*EVT_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]           src_ack,
    output logic [WIDTH-1:0]             fifo_din,
    output logic                         fifo_write,
    input  logic                         fifo_full,
    output logic                         busy,
    output logic [15:0]                  stall_cnt
);

    localparam int ID_WIDTH = id_width(NUM_SRC);
    localparam int TS_WIDTH = ts_width(WIDTH, EVT_WIDTH, NUM_SRC);

    if (TS_WIDTH < 4) begin : g_ts_too_narrow
        $error("trace_arbiter: timestamp field is %0d bits, at least 4 required", TS_WIDTH);
    end
    if (NUM_SRC < 2 || NUM_SRC > 8) begin : g_bad_num_src
        $error("trace_arbiter: NUM_SRC=%0d outside 2..8", NUM_SRC);
    end

    // Reset asserts immediately but releases two clocks after rstn rises.
    logic [1:0] rst_sync;
    logic       core_rst_n;

    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: clocked state is always updated with non-blocking assignments so
        // every flop samples pre-edge values regardless of statement order.
        if (!rstn) rst_sync <= 2'b00;
        else       rst_sync <= {rst_sync[0], 1'b1};
    end

    assign core_rst_n = rst_sync[1];

    state_t                state_q, state_d;
    logic [TS_WIDTH-1:0]   ts_q;
    logic [ID_WIDTH-1:0]   rr_ptr_q, next_ptr;
    logic [15:0]           stall_q;
    logic [WIDTH-1:0]      record_q, new_record;
    logic [NUM_SRC-1:0]    ack_q, ack_d;
    logic                  grant_valid;
    logic [ID_WIDTH-1:0]   grant_idx;
    logic [EVT_WIDTH-1:0]  payload;
    logic                  write_ok;
    logic                  load;

    // The source acked this cycle still shows its old request; mask it.
    rr_arbiter #(
        .NUM_REQ  (NUM_SRC),
        .IDX_WIDTH(ID_WIDTH)
    ) u_rr (
        .req        (src_req),
        .mask       (ack_q),
        .ptr        (rr_ptr_q),
        .grant_valid(grant_valid),
        .grant_idx  (grant_idx)
    );

    assign write_ok   = (state_q == ST_WRITE) && !fifo_full;
    assign payload    = src_data[int'(grant_idx)*EVT_WIDTH +: EVT_WIDTH];
    assign new_record = {grant_idx, ts_q, payload};
    assign next_ptr   = (grant_idx == ID_WIDTH'(NUM_SRC - 1)) ? '0 : grant_idx + ID_WIDTH'(1);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ack_d   = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && grant_valid) begin
                    load    = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // A stalled record holds; a drained one chains straight into the next.
                if (!fifo_full) begin
                    if (enable && grant_valid) load = 1'b1;
                    else                       state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (load) ack_d[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q  <= ST_IDLE;
            ts_q     <= '0;
            rr_ptr_q <= '0;
            stall_q  <= '0;
            record_q <= '0;
            ack_q    <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            if (enable) ts_q <= ts_q + TS_WIDTH'(1);
            if (load) begin
                record_q <= new_record;
                rr_ptr_q <= next_ptr;
            end
            if (state_q == ST_WRITE && fifo_full && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign src_ack    = ack_q;
    assign fifo_din   = record_q;
    assign fifo_write = write_ok;
    assign busy       = (state_q != ST_IDLE);
    assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_trace_arbiter.sv
// Directed bench for trace_arbiter: inputs driven and outputs sampled on the
// falling edge; sources drop or advance their event when they see an ack.
module tb_trace_arbiter;

    localparam int NUM_SRC   = 4;
    localparam int EVT_WIDTH = 16;
    localparam int WIDTH     = 32;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_full = 1'b0;
    logic [3:0]  src_req = '0;
    logic [63:0] src_data = '0;
    logic [3:0]  src_ack;
    logic [31:0] fifo_din;
    logic        fifo_write;
    logic        busy;
    logic [15:0] stall_cnt;

    int          total = 0;
    int          bad = 0;
    logic [15:0] evt_base [4];
    int          evt_left [4];
    int          evt_idx  [4];

    always #5 clk = ~clk;

    trace_arbiter #(
        .NUM_SRC  (NUM_SRC),
        .EVT_WIDTH(EVT_WIDTH),
        .WIDTH    (WIDTH)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .src_req   (src_req),
        .src_data  (src_data),
        .src_ack   (src_ack),
        .fifo_din  (fifo_din),
        .fifo_write(fifo_write),
        .fifo_full (fifo_full),
        .busy      (busy),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rec(input int id, input int ts, input logic [15:0] pl);
        return {2'(id), 14'(ts), pl};
    endfunction

    task automatic load(input int i, input logic [15:0] base, input int n);
        evt_base[i] = base;
        evt_left[i] = n;
        evt_idx[i]  = 0;
        src_data[i*16 +: 16] = base;
        src_req[i] = 1'b1;
    endtask

    task automatic serve();
        for (int i = 0; i < 4; i++) begin
            if (src_ack[i] && evt_left[i] > 0) begin
                evt_left[i]--;
                evt_idx[i]++;
                if (evt_left[i] == 0) src_req[i] = 1'b0;
                else src_data[i*16 +: 16] = evt_base[i] + 16'(evt_idx[i]);
            end
        end
    endtask

    task automatic do_reset();
        src_req   = '0;
        enable    = 1'b0;
        fifo_full = 1'b0;
        rstn      = 1'b0;
        for (int i = 0; i < 4; i++) evt_left[i] = 0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
        tick();
        tick();
    endtask

    initial begin
        // Reset state and a single event at ts=5
        do_reset();
        check("rst_ack", 32'(src_ack), 32'h0);
        check("rst_din", fifo_din, 32'h0);
        check("rst_wr", 32'(fifo_write), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_stall", 32'(stall_cnt), 32'h0);
        enable = 1'b1;
        repeat (5) tick();
        load(2, 16'h1234, 1);
        tick();
        check("single_ack", 32'(src_ack), 32'h4);
        check("single_wr", 32'(fifo_write), 32'h1);
        check("single_din", fifo_din, 32'h8005_1234);
        check("single_busy", 32'(busy), 32'h1);
        serve();
        tick();
        check("single_ack_off", 32'(src_ack), 32'h0);
        check("single_wr_off", 32'(fifo_write), 32'h0);
        check("single_idle", 32'(busy), 32'h0);

        // Fairness: four sources, two events each, back to back
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) load(i, 16'hA000 + 16'(i*256), 2);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("fair_wr", 32'(fifo_write), 32'h1);
            check("fair_ack", 32'(src_ack), 32'(1 << (k % 4)));
            check("fair_din", fifo_din, rec(k % 4, k, 16'hA000 + 16'((k % 4)*256 + k/4)));
            serve();
        end
        tick();
        check("fair_wr_end", 32'(fifo_write), 32'h0);
        check("fair_idle", 32'(busy), 32'h0);

        // Backpressure: ten blocked cycles, then the held record drains
        do_reset();
        enable    = 1'b1;
        fifo_full = 1'b1;
        load(0, 16'hBEEF, 1);
        tick();
        check("bp_ack", 32'(src_ack), 32'h1);
        check("bp_wr_first", 32'(fifo_write), 32'h0);
        check("bp_din_first", fifo_din, 32'h0000_BEEF);
        serve();
        for (int k = 2; k <= 11; k++) begin
            tick();
            check("bp_wr_blocked", 32'(fifo_write), 32'h0);
            check("bp_din_hold", fifo_din, 32'h0000_BEEF);
            check("bp_ack_off", 32'(src_ack), 32'h0);
            check("bp_busy", 32'(busy), 32'h1);
        end
        check("bp_stall", 32'(stall_cnt), 32'd10);
        fifo_full = 1'b0;
        #1;
        check("bp_wr_release", 32'(fifo_write), 32'h1);
        check("bp_din_release", fifo_din, 32'h0000_BEEF);
        tick();
        check("bp_idle", 32'(busy), 32'h0);
        check("bp_wr_end", 32'(fifo_write), 32'h0);
        check("bp_stall_hold", 32'(stall_cnt), 32'd10);

        // Timestamp wrap from 16383 to 0 across consecutive records
        do_reset();
        enable = 1'b1;
        repeat (16383) tick();
        load(0, 16'h1111, 1);
        load(1, 16'h2222, 1);
        tick();
        check("wrap_din_max", fifo_din, 32'h3FFF_1111);
        check("wrap_wr_max", 32'(fifo_write), 32'h1);
        serve();
        tick();
        check("wrap_din_zero", fifo_din, 32'h4000_2222);
        check("wrap_wr_zero", 32'(fifo_write), 32'h1);
        serve();
        tick();
        check("wrap_idle", 32'(busy), 32'h0);

        // Reset while a stalled record is held
        do_reset();
        enable    = 1'b1;
        fifo_full = 1'b1;
        load(2, 16'h5555, 1);
        tick();
        check("rw_busy", 32'(busy), 32'h1);
        check("rw_ack", 32'(src_ack), 32'h4);
        serve();
        tick();
        rstn = 1'b0;
        #1;
        check("rw_wr", 32'(fifo_write), 32'h0);
        check("rw_busy_rst", 32'(busy), 32'h0);
        check("rw_ack_rst", 32'(src_ack), 32'h0);
        check("rw_din_rst", fifo_din, 32'h0);
        check("rw_stall_rst", 32'(stall_cnt), 32'h0);
        fifo_full = 1'b0;
        load(1, 16'h0111, 1);
        load(2, 16'h0222, 1);
        tick();
        rstn = 1'b1;
        tick();
        check("rw_sync1", 32'(busy), 32'h0);
        tick();
        check("rw_sync2", 32'(busy), 32'h0);
        tick();
        check("rw_first_din", fifo_din, 32'h4000_0111);
        check("rw_first_ack", 32'(src_ack), 32'h2);
        check("rw_first_wr", 32'(fifo_write), 32'h1);
        serve();
        tick();
        check("rw_second_din", fifo_din, 32'h8001_0222);
        check("rw_second_ack", 32'(src_ack), 32'h4);
        serve();
        tick();
        check("rw_idle", 32'(busy), 32'h0);

        // Enable dropped mid-stream while the FIFO is full
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) load(i, 16'h1000 * 16'(i + 1), 1);
        tick();
        check("en_din0", fifo_din, 32'h0000_1000);
        check("en_ack0", 32'(src_ack), 32'h1);
        serve();
        tick();
        check("en_din1", fifo_din, 32'h4001_2000);
        check("en_ack1", 32'(src_ack), 32'h2);
        serve();
        enable    = 1'b0;
        fifo_full = 1'b1;
        tick();
        check("en_hold_busy", 32'(busy), 32'h1);
        check("en_hold_wr", 32'(fifo_write), 32'h0);
        check("en_hold_ack", 32'(src_ack), 32'h0);
        check("en_hold_din", fifo_din, 32'h4001_2000);
        fifo_full = 1'b0;
        #1;
        check("en_drain_wr", 32'(fifo_write), 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("en_off_busy", 32'(busy), 32'h0);
            check("en_off_ack", 32'(src_ack), 32'h0);
            check("en_off_wr", 32'(fifo_write), 32'h0);
        end
        enable = 1'b1;
        tick();
        check("en_resume_din", fifo_din, 32'h8002_3000);
        check("en_resume_ack", 32'(src_ack), 32'h4);
        serve();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
